// File: rtl/instr_fetch_queue_if.sv
// Handshake bundle between the fetch queue, instruction memory and the decoder.
// master = fetch queue side, slave = memory/decoder/control environment side.
interface instr_fetch_queue_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic [6:0]  current_opcode;
    logic [3:0]  current_func;

    modport master (
        output imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
               current_opcode, current_func,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect, redirect_pc,
               dec_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, dec_valid, dec_instr, dec_pc,
               current_opcode, current_func,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect, redirect_pc,
               dec_ready
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch stage: sequential PC generation, credit-limited imem requests and an in-order
// prefetch FIFO presenting the head instruction with pre-split opcode/func fields.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                 clk,
    input logic                 reset,
    instr_fetch_queue_if.master bus
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {StRun, StDrain} state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [AW:0]   outst_q, outst_d;
    logic [AW:0]   discard_q, discard_d;
    logic [AW:0]   occ_q, occ_d;
    logic [AW-1:0] fifo_wptr_q, fifo_wptr_d, fifo_rptr_q, fifo_rptr_d;
    logic [AW-1:0] tag_wptr_q, tag_wptr_d, tag_rptr_q, tag_rptr_d;

    logic [31:0]   tag_mem   [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc_mem    [DEPTH];

    logic [AW+1:0] credit_sum;
    logic          req_valid, accept, resp, push, pop, fifo_nonempty;
    logic [31:0]   dec_instr;

    // Reserving a FIFO slot for every outstanding request means responses never overflow.
    assign credit_sum    = {1'b0, occ_q} + {1'b0, outst_q};
    assign req_valid     = (state_q == StRun) && !reset && (credit_sum < (AW+2)'(DEPTH));
    assign accept        = req_valid && bus.imem_req_ready;
    assign resp          = bus.imem_resp_valid;
    assign push          = resp && (discard_q == '0) && !bus.redirect;
    assign fifo_nonempty = (occ_q != '0);
    assign pop           = fifo_nonempty && bus.dec_ready && !bus.redirect;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        discard_d   = discard_q;
        outst_d     = outst_q + (AW+1)'(accept) - (AW+1)'(resp);
        occ_d       = occ_q + (AW+1)'(push) - (AW+1)'(pop);
        fifo_wptr_d = fifo_wptr_q + AW'(push);
        fifo_rptr_d = fifo_rptr_q + AW'(pop);
        tag_wptr_d  = tag_wptr_q + AW'(accept);
        tag_rptr_d  = tag_rptr_q + AW'(push);
        if (bus.redirect) begin
            // Everything still in flight, including this cycle's accept, becomes stale.
            pc_d        = bus.redirect_pc & ~32'h3;
            discard_d   = outst_d;
            state_d     = (outst_d != '0) ? StDrain : StRun;
            occ_d       = '0;
            fifo_wptr_d = '0;
            fifo_rptr_d = '0;
            tag_wptr_d  = '0;
            tag_rptr_d  = '0;
        end else begin
            if (accept) begin
                pc_d = pc_q + 32'd4;
            end
            if (resp && (discard_q != '0)) begin
                discard_d = discard_q - 1'b1;
            end
            if ((state_q == StDrain) && (discard_d == '0)) begin
                state_d = StRun;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StRun;
            pc_q        <= RESET_PC;
            outst_q     <= '0;
            discard_q   <= '0;
            occ_q       <= '0;
            fifo_wptr_q <= '0;
            fifo_rptr_q <= '0;
            tag_wptr_q  <= '0;
            tag_rptr_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            outst_q     <= outst_d;
            discard_q   <= discard_d;
            occ_q       <= occ_d;
            fifo_wptr_q <= fifo_wptr_d;
            fifo_rptr_q <= fifo_rptr_d;
            tag_wptr_q  <= tag_wptr_d;
            tag_rptr_q  <= tag_rptr_d;
        end
    end

    // Storage needs no reset: occupancy gates every read.
    always_ff @(posedge clk) begin
        if (accept) begin
            tag_mem[tag_wptr_q] <= pc_q;
        end
        if (push) begin
            instr_mem[fifo_wptr_q] <= bus.imem_resp_data;
            pc_mem[fifo_wptr_q]    <= tag_mem[tag_rptr_q];
        end
    end

    assign dec_instr          = fifo_nonempty ? instr_mem[fifo_rptr_q] : '0;
    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc_q;
    assign bus.dec_valid      = fifo_nonempty;
    assign bus.dec_instr      = dec_instr;
    assign bus.dec_pc         = fifo_nonempty ? pc_mem[fifo_rptr_q] : '0;
    assign bus.current_opcode = dec_instr[6:0];
    assign bus.current_func   = {dec_instr[30], dec_instr[14:12]};
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: in-order memory model with variable latency, scoreboard of
// expected PC stream per fetch epoch, directed scenarios followed by a random phase.
module tb_instr_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    instr_fetch_queue_if bus ();

    instr_fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int pops    = 0;

    // Memory model state
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] acc_log[$];
    int          cyc        = 0;
    int          lat_min    = 1;
    int          lat_max    = 1;
    bit          ready_en   = 1'b1;
    bit          ready_rand = 1'b0;

    // Scoreboard: expected PCs delivered to decode in the current epoch
    logic [31:0] exp_q[$];
    logic [31:0] next_pc = RESET_PC;

    // Directed-test scratch
    int          first_valid;
    int          nvalid;
    int          nacc;
    bit          seen;
    logic [31:0] wrap_exp [3];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0300) return 32'h40B5_0533;
        if (a == 32'h0000_0304) return 32'h00A5_0513;
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic refill();
        while (exp_q.size() < 4) begin
            exp_q.push_back(next_pc);
            next_pc = next_pc + 32'd4;
        end
    endtask

    task automatic wait_valid(input int budget, input string name);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (bus.dec_valid) seen = 1'b1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] target);
        @(posedge clk); #1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = target;
        @(posedge clk); #1;
        bus.redirect    = 1'b0;
    endtask

    // Memory: responds in request order once each request's latency has elapsed.
    initial begin
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            bus.imem_req_ready = ready_en && (!ready_rand || ($urandom_range(0, 3) != 0));
            if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
                bus.imem_resp_valid = 1'b1;
                bus.imem_resp_data  = mem_word(pend_addr[0]);
            end else begin
                bus.imem_resp_valid = 1'b0;
                bus.imem_resp_data  = $urandom();
            end
        end
    end

    // Monitor: memory bookkeeping and scoreboard comparison on each decode handshake.
    always @(negedge clk) begin
        logic [31:0] e;
        logic [31:0] w;
        if (bus.imem_resp_valid && pend_addr.size() > 0) begin
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            acc_log.push_back(bus.imem_req_addr);
            pend_addr.push_back(bus.imem_req_addr);
            pend_due.push_back(cyc + int'($urandom_range(lat_min, lat_max)));
        end
        if (reset) begin
            pend_addr.delete();
            pend_due.delete();
            exp_q.delete();
            next_pc = RESET_PC;
            refill();
        end else if (bus.redirect) begin
            exp_q.delete();
            next_pc = bus.redirect_pc & ~32'h3;
            refill();
        end else if (bus.dec_valid && bus.dec_ready) begin
            refill();
            e = exp_q.pop_front();
            w = mem_word(e);
            check("dec_pc", bus.dec_pc, e);
            check("dec_instr", bus.dec_instr, w);
            check("opcode", 32'(bus.current_opcode), 32'(w[6:0]));
            check("func", 32'(bus.current_func), 32'({w[30], w[14:12]}));
            pops++;
        end
        if (!reset && !bus.dec_valid) begin
            check("empty_fields", 32'({bus.current_opcode, bus.current_func}), 32'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.dec_ready   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
        check("rst_dec_instr", bus.dec_instr, 32'd0);
        check("rst_dec_pc", bus.dec_pc, 32'd0);
        check("rst_req_addr", bus.imem_req_addr, RESET_PC);

        // Sustained one-per-cycle delivery after a two-cycle fill
        @(posedge clk); #1;
        reset         = 1'b0;
        bus.dec_ready = 1'b1;
        first_valid   = -1;
        nvalid        = 0;
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            if (i == 0) check("t1_first_addr", bus.imem_req_addr, RESET_PC);
            if (bus.dec_valid) begin
                nvalid++;
                if (first_valid < 0) first_valid = i;
            end
        end
        check("t1_fill_latency", 32'(first_valid), 32'd2);
        check("t1_throughput", 32'(nvalid), 32'd20);

        // Back-pressure: credit limit stops fetch at DEPTH requests
        bus.dec_ready = 1'b0;
        pulse_reset();
        nacc = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (bus.imem_req_valid && bus.imem_req_ready) nacc++;
        end
        check("t2_accepts", 32'(nacc), DEPTH);
        check("t2_req_stall", 32'(bus.imem_req_valid), 32'd0);
        @(posedge clk); #1;
        bus.dec_ready = 1'b1;
        repeat (10) @(posedge clk);

        // Redirect with two responses in flight
        lat_min = 2;
        lat_max = 2;
        repeat (12) @(posedge clk);
        do_redirect(32'h0000_0203);
        @(negedge clk);
        check("t3_dec_valid_after_redirect", 32'(bus.dec_valid), 32'd0);
        check("t3_drain_req0", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        check("t3_drain_req1", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        check("t3_run_req", 32'(bus.imem_req_valid), 32'd1);
        check("t3_run_addr", bus.imem_req_addr, 32'h0000_0200);
        wait_valid(20, "t3_wait");
        check("t3_first_pc", bus.dec_pc, 32'h0000_0200);

        // Opcode/func split for known encodings
        lat_min = 1;
        lat_max = 1;
        @(posedge clk); #1;
        bus.dec_ready = 1'b0;
        do_redirect(32'h0000_0300);
        wait_valid(20, "t4_wait");
        check("t4_sub_opcode", 32'(bus.current_opcode), 32'(7'b0110011));
        check("t4_sub_func", 32'(bus.current_func), 32'(4'b1000));
        @(posedge clk); #1;
        bus.dec_ready = 1'b1;
        @(posedge clk); #1;
        bus.dec_ready = 1'b0;
        @(negedge clk);
        check("t4_addi_pc", bus.dec_pc, 32'h0000_0304);
        check("t4_addi_opcode", 32'(bus.current_opcode), 32'(7'b0010011));
        check("t4_addi_func", 32'(bus.current_func), 32'(4'b0000));

        // Memory stall holds the address; PC wraps past 0xFFFF_FFFC
        ready_en = 1'b0;
        @(posedge clk); #1;
        bus.dec_ready = 1'b1;
        do_redirect(32'hFFFF_FFF8);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5_addr_held", bus.imem_req_addr, 32'hFFFF_FFF8);
        end
        acc_log.delete();
        ready_en = 1'b1;
        repeat (10) @(negedge clk);
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        for (int i = 0; i < 3; i++) begin
            check("t5_wrap_addr", (i < acc_log.size()) ? acc_log[i] : 32'hDEAD_BEEF,
                  wrap_exp[i]);
        end

        // Reset wins over a same-cycle redirect with a full FIFO
        @(posedge clk); #1;
        bus.dec_ready = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_full_valid", 32'(bus.dec_valid), 32'd1);
        @(posedge clk); #1;
        reset           = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0500;
        @(posedge clk); #1;
        reset        = 1'b0;
        bus.redirect = 1'b0;
        @(negedge clk);
        check("t6_dec_valid", 32'(bus.dec_valid), 32'd0);
        check("t6_req_addr", bus.imem_req_addr, RESET_PC);
        check("t6_req_valid", 32'(bus.imem_req_valid), 32'd1);
        @(posedge clk); #1;
        bus.dec_ready = 1'b1;
        repeat (10) @(posedge clk);

        // Random traffic: back-pressure on both sides, variable latency, redirects, resets
        ready_rand = 1'b1;
        lat_min    = 1;
        lat_max    = 4;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            bus.dec_ready   = ($urandom_range(0, 3) != 0);
            bus.redirect    = ($urandom_range(0, 39) == 0);
            bus.redirect_pc = $urandom();
            reset           = ($urandom_range(0, 499) == 0);
        end
        @(posedge clk); #1;
        bus.redirect  = 1'b0;
        reset         = 1'b0;
        bus.dec_ready = 1'b1;
        ready_rand    = 1'b0;
        repeat (20) @(posedge clk);
        check("liveness_pops", 32'(pops > 800), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
